// File: rtl/store_queue_pkg.sv
// Shared store-queue definitions (package sys_defs).
//   SQ_DEPTH        number of store-queue entries (power of 2)
//   LSQ             entry index width, also the width of a load's tail_pos
//   SQ_ENTRY        one queue entry {resolved, addr, data, usebytes}
//   LOAD_SQ_PACKET  load FU lookup request {addr, tail_pos}
//   SQ_LOAD_PACKET  lookup answer {stall, usebytes, data}
package sys_defs;

    localparam int unsigned SQ_DEPTH = 8;
    localparam int unsigned LSQ      = $clog2(SQ_DEPTH);

    typedef struct packed {
        logic        resolved;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  usebytes;
    } SQ_ENTRY;

    typedef struct packed {
        logic [31:0]    addr;
        logic [LSQ-1:0] tail_pos;
    } LOAD_SQ_PACKET;

    typedef struct packed {
        logic        stall;
        logic [3:0]  usebytes;
        logic [31:0] data;
    } SQ_LOAD_PACKET;

endpackage

// File: rtl/store_queue_sq_forward.sv
// Combinational store-to-load forwarding for the store queue.
//   entries    full entry array (physical order)
//   head       index of the oldest live entry
//   live       number of live entries (tail - head, 0..SQ_DEPTH)
//   sq_lookup  load address and the load's tail_pos
//   sq_result  stall, or per-byte forwarded data from the youngest older store
module sq_forward
    import sys_defs::*;
(
    input  SQ_ENTRY [SQ_DEPTH-1:0] entries,
    input  logic    [LSQ-1:0]      head,
    input  logic    [LSQ:0]        live,
    input  LOAD_SQ_PACKET          sq_lookup,
    output SQ_LOAD_PACKET          sq_result
);

    SQ_ENTRY [SQ_DEPTH-1:0] aged;
    logic    [SQ_DEPTH-1:0] older;
    logic    [LSQ-1:0]      n_older;
    logic                   stall;
    logic    [3:0]          usebytes;
    logic    [31:0]         data;

    // Age order: aged[0] is the oldest entry (head), higher index is younger.
    assign n_older = sq_lookup.tail_pos - head;

    always_comb begin
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            aged[i]  = entries[head + LSQ'(i)];
            // Positions at or beyond tail are free slots, never older stores.
            older[i] = (LSQ'(i) < n_older) && ((LSQ + 1)'(i) < live);
        end
    end

    always_comb begin
        stall    = 1'b0;
        usebytes = '0;
        data     = '0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if (older[i] && !aged[i].resolved) begin
                stall = 1'b1;
            end
        end
        // Walk oldest to youngest so the youngest matching store wins each byte.
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if (older[i] && (aged[i].addr == sq_lookup.addr)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (aged[i].usebytes[b]) begin
                        usebytes[b]    = 1'b1;
                        data[8*b +: 8] = aged[i].data[8*b +: 8];
                    end
                end
            end
        end
        if (stall) begin
            sq_result = '{stall: 1'b1, usebytes: 4'b0, data: 32'b0};
        end else begin
            sq_result = '{stall: 1'b0, usebytes: usebytes, data: data};
        end
    end

endmodule

// File: rtl/store_queue.sv
// In-order circular store queue.
//   clock/reset_n     clock, asynchronous active-low reset
//   dp_*              store dispatch: allocate entry at tail, report its index
//   ex_*              store FU result: fill address/data/byte enables of an entry
//   rt_valid          ROB retires (commits) the oldest uncommitted store
//   squash            drop all uncommitted entries
//   sq_lookup/result  0-cycle load forwarding lookup
//   dc_wr_*           drain committed, resolved stores to the D-cache in order
module store_queue
    import sys_defs::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 dp_valid,
    output logic                 dp_ready,
    output logic [LSQ-1:0]       dp_tail,
    input  logic                 ex_valid,
    input  logic [LSQ-1:0]       ex_idx,
    input  logic [31:0]          ex_addr,
    input  logic [31:0]          ex_data,
    input  logic [3:0]           ex_usebytes,
    input  logic                 rt_valid,
    input  logic                 squash,
    input  LOAD_SQ_PACKET        sq_lookup,
    output SQ_LOAD_PACKET        sq_result,
    output logic                 dc_wr_valid,
    input  logic                 dc_wr_ready,
    output logic [31:0]          dc_wr_addr,
    output logic [31:0]          dc_wr_data,
    output logic [3:0]           dc_wr_bytes
);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [LSQ:0] head_q, head_d;
    logic [LSQ:0] commit_q, commit_d;
    logic [LSQ:0] tail_q, tail_d;

    SQ_ENTRY [SQ_DEPTH-1:0] entries_q;

    logic [LSQ-1:0] head_idx;
    logic [LSQ-1:0] tail_idx;
    logic           full;
    logic           dp_fire;
    logic           ex_fire;
    logic           drain_fire;

    assign head_idx = head_q[LSQ-1:0];
    assign tail_idx = tail_q[LSQ-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[LSQ] != tail_q[LSQ]);

    assign dp_ready = !full;
    assign dp_tail  = tail_idx;

    // Dispatch and execute are dropped in a squash cycle; full is judged
    // before any drain in the same cycle.
    assign dp_fire = dp_valid && !full && !squash;
    assign ex_fire = ex_valid && !squash;

    assign dc_wr_valid = (head_q != commit_q) && entries_q[head_idx].resolved;
    assign dc_wr_addr  = entries_q[head_idx].addr;
    assign dc_wr_data  = entries_q[head_idx].data;
    assign dc_wr_bytes = entries_q[head_idx].usebytes;
    assign drain_fire  = dc_wr_valid && dc_wr_ready;

    always_comb begin
        head_d   = head_q + (LSQ + 1)'(drain_fire);
        commit_d = commit_q + (LSQ + 1)'(rt_valid);
        // A retire in the squash cycle still counts, so squash lands on it.
        tail_d   = squash ? commit_d : tail_q + (LSQ + 1)'(dp_fire);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            commit_q  <= '0;
            tail_q    <= '0;
            entries_q <= '0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            if (dp_fire) begin
                entries_q[tail_idx].resolved <= 1'b0;
            end
            if (ex_fire) begin
                entries_q[ex_idx] <= '{resolved: 1'b1, addr: ex_addr, data: ex_data,
                                       usebytes: ex_usebytes};
            end
            if (drain_fire) begin
                entries_q[head_idx].resolved <= 1'b0;
            end
        end
    end

    sq_forward u_sq_forward (
        .entries   (entries_q),
        .head      (head_idx),
        .live      (tail_q - head_q),
        .sq_lookup (sq_lookup),
        .sq_result (sq_result)
    );

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
    import sys_defs::*;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 dp_valid, dp_ready;
    logic [LSQ-1:0]       dp_tail;
    logic                 ex_valid;
    logic [LSQ-1:0]       ex_idx;
    logic [31:0]          ex_addr, ex_data;
    logic [3:0]           ex_usebytes;
    logic                 rt_valid, squash;
    LOAD_SQ_PACKET        sq_lookup;
    SQ_LOAD_PACKET        sq_result;
    logic                 dc_wr_valid, dc_wr_ready;
    logic [31:0]          dc_wr_addr, dc_wr_data;
    logic [3:0]           dc_wr_bytes;

    store_queue dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .dp_valid    (dp_valid),
        .dp_ready    (dp_ready),
        .dp_tail     (dp_tail),
        .ex_valid    (ex_valid),
        .ex_idx      (ex_idx),
        .ex_addr     (ex_addr),
        .ex_data     (ex_data),
        .ex_usebytes (ex_usebytes),
        .rt_valid    (rt_valid),
        .squash      (squash),
        .sq_lookup   (sq_lookup),
        .sq_result   (sq_result),
        .dc_wr_valid (dc_wr_valid),
        .dc_wr_ready (dc_wr_ready),
        .dc_wr_addr  (dc_wr_addr),
        .dc_wr_data  (dc_wr_data),
        .dc_wr_bytes (dc_wr_bytes)
    );

    always #5 clock = ~clock;

    // Reference model: program-ordered list of live stores, oldest first.
    typedef struct {
        bit          resolved;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bytes;
    } ment_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bytes;
    } wr_t;
    typedef struct {
        bit            dp_ready;
        int            dp_tail;
        bit            dcv;
        wr_t           wr;
        SQ_LOAD_PACKET lk;
    } exp_t;
    typedef struct {
        bit          dpv, exv, rtv, sq, rdy;
        int          exi;
        logic [31:0] exa, exd;
        logic [3:0]  exb;
        logic [31:0] lka;
        int          lkp;
    } stim_t;

    ment_t mq[$];
    wr_t   wq[$];
    exp_t  eq[$];
    int    head_seq = 0;
    int    ncommit = 0;
    int    total = 0;
    int    bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int hidx();
        return head_seq % SQ_DEPTH;
    endfunction

    function automatic SQ_LOAD_PACKET model_lookup(input logic [31:0] a, input int tp);
        SQ_LOAD_PACKET r;
        int n;
        r = '0;
        n = (tp - hidx() + SQ_DEPTH) % SQ_DEPTH;
        if (n > mq.size()) n = mq.size();
        for (int k = 0; k < n; k++) begin
            if (!mq[k].resolved) begin
                r.stall = 1'b1;
                return r;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (mq[k].addr == a) begin
                for (int b = 0; b < 4; b++) begin
                    if (mq[k].bytes[b]) begin
                        r.usebytes[b]  = 1'b1;
                        r.data[8*b+:8] = mq[k].data[8*b+:8];
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{dpv: 0, exv: 0, rtv: 0, sq: 0, rdy: 0, exi: 0, exa: 0, exd: 0, exb: 0,
              lka: 32'h100, lkp: 0};
        s.lkp = (head_seq + mq.size()) % SQ_DEPTH;
        return s;
    endfunction

    task automatic drive_idle();
        dp_valid = 0; ex_valid = 0; ex_idx = '0; ex_addr = '0; ex_data = '0;
        ex_usebytes = '0; rt_valid = 0; squash = 0; dc_wr_ready = 0;
        sq_lookup = '{addr: 32'h0, tail_pos: '0};
    endtask

    task automatic model_update(input stim_t s);
        bit    drain;
        bit    full;
        int    k;
        ment_t m;
        drain = (ncommit > 0) && mq[0].resolved && s.rdy;
        full  = (mq.size() == SQ_DEPTH);
        if (!s.sq && s.exv) begin
            k = (s.exi - hidx() + SQ_DEPTH) % SQ_DEPTH;
            mq[k] = '{resolved: 1, addr: s.exa, data: s.exd, bytes: s.exb};
        end
        if (s.rtv) begin
            wq.push_back('{addr: mq[ncommit].addr, data: mq[ncommit].data,
                           bytes: mq[ncommit].bytes});
            ncommit++;
        end
        if (!s.sq && s.dpv && !full) begin
            m = '{resolved: 0, addr: 0, data: 0, bytes: 0};
            mq.push_back(m);
        end
        if (s.sq) begin
            while (mq.size() > ncommit) void'(mq.pop_back());
        end
        if (drain) begin
            void'(mq.pop_front());
            head_seq++;
            ncommit--;
        end
    endtask

    // Entered #1 after a rising edge; returns #1 after the next one.
    task automatic step(input stim_t s);
        exp_t e;
        dp_valid    = s.dpv;
        ex_valid    = s.exv;
        ex_idx      = LSQ'(s.exi);
        ex_addr     = s.exa;
        ex_data     = s.exd;
        ex_usebytes = s.exb;
        rt_valid    = s.rtv;
        squash      = s.sq;
        dc_wr_ready = s.rdy;
        sq_lookup   = '{addr: s.lka, tail_pos: LSQ'(s.lkp)};
        e.dp_ready  = (mq.size() < SQ_DEPTH);
        e.dp_tail   = (head_seq + mq.size()) % SQ_DEPTH;
        e.dcv       = (ncommit > 0) && mq[0].resolved;
        e.wr        = '{addr: 0, data: 0, bytes: 0};
        if (e.dcv) e.wr = '{addr: mq[0].addr, data: mq[0].data, bytes: mq[0].bytes};
        e.lk        = model_lookup(s.lka, s.lkp);
        eq.push_back(e);
        @(posedge clock);
        model_update(s);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive_idle();
        mq.delete();
        wq.delete();
        head_seq = 0;
        ncommit  = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: per-cycle expectations and D-cache write handshakes.
    always @(negedge clock) begin
        exp_t e;
        wr_t  w;
        if (reset_n && eq.size() > 0) begin
            e = eq.pop_front();
            chk("dp_ready", 64'(dp_ready), 64'(e.dp_ready));
            chk("dp_tail", 64'(dp_tail), 64'(e.dp_tail));
            chk("dc_wr_valid", 64'(dc_wr_valid), 64'(e.dcv));
            if (e.dcv) begin
                chk("dc_wr_addr", 64'(dc_wr_addr), 64'(e.wr.addr));
                chk("dc_wr_data", 64'(dc_wr_data), 64'(e.wr.data));
                chk("dc_wr_bytes", 64'(dc_wr_bytes), 64'(e.wr.bytes));
            end
            chk("sq_result", 64'(sq_result), 64'(e.lk));
        end
        if (reset_n && dc_wr_valid && dc_wr_ready) begin
            if (wq.size() == 0) begin
                chk("dc_write_unexpected", 64'(dc_wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("dc_write", {dc_wr_addr, dc_wr_data}, {w.addr, w.data});
                chk("dc_write_bytes", 64'(dc_wr_bytes), 64'(w.bytes));
            end
        end
    end

    function automatic logic [31:0] pick_addr();
        logic [31:0] tbl [3];
        tbl[0] = 32'h100; tbl[1] = 32'h104; tbl[2] = 32'h200;
        return tbl[$urandom_range(0, 2)];
    endfunction

    initial begin
        stim_t s;
        int    ul[$];
        int    off;
        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Fill to full; the 9th dispatch must be refused.
        for (int i = 0; i < 9; i++) begin
            s = idle(); s.dpv = 1; step(s);
        end
        s = idle(); s.exv = 1; s.exi = 0; s.exa = 32'h40; s.exd = 32'h1234_5678; s.exb = 4'hF;
        step(s);
        s = idle(); s.rtv = 1; step(s);
        s = idle(); s.rdy = 1; s.dpv = 1; step(s);   // drain while full: no dispatch
        s = idle(); s.dpv = 1; step(s);              // wraps to index 0

        // Reset with 5 live entries.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.dpv = 1; step(s);
        end
        do_reset();
        s = idle(); s.lkp = 0; step(s);

        // Forward merge of A then B at 0x100.
        s = idle(); s.dpv = 1; step(s);
        s = idle(); s.dpv = 1; step(s);
        s = idle(); s.exv = 1; s.exi = 0; s.exa = 32'h100; s.exd = 32'h0000_BEEF; s.exb = 4'b0011;
        step(s);
        s = idle(); s.exv = 1; s.exi = 1; s.exa = 32'h100; s.exd = 32'h00CA_FE00; s.exb = 4'b0110;
        step(s);
        s = idle(); s.lka = 32'h100; s.lkp = 2; step(s);

        // Stall on unresolved C (index 2).
        s = idle(); s.dpv = 1; step(s);
        s = idle(); s.lkp = 3; step(s);
        s = idle(); s.lkp = 2; step(s);
        s = idle(); s.lkp = 3; s.exv = 1; s.exi = 2; s.exa = 32'h100; s.exd = 32'hAA00_0000;
        s.exb = 4'b1000; step(s);
        s = idle(); s.lkp = 3; step(s);

        // Squash: A, B committed; C plus three more uncommitted. Then backpressure.
        s = idle(); s.rtv = 1; step(s);
        s = idle(); s.rtv = 1; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.dpv = 1; step(s);
        end
        s = idle(); s.sq = 1; s.dpv = 1; step(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.lkp = 2; step(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rdy = 1; step(s);
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) do_reset();
            s = idle();
            s.dpv = 1'($urandom_range(0, 1));
            ul.delete();
            for (int k = 0; k < mq.size(); k++) if (!mq[k].resolved) ul.push_back(k);
            if (ul.size() > 0 && $urandom_range(0, 9) < 6) begin
                s.exv = 1;
                s.exi = (head_seq + ul[$urandom_range(0, ul.size() - 1)]) % SQ_DEPTH;
                s.exa = pick_addr();
                s.exd = $urandom;
                s.exb = 4'($urandom_range(1, 15));
            end
            if (ncommit < mq.size() && mq[ncommit].resolved && $urandom_range(0, 9) < 4) s.rtv = 1;
            s.sq  = ($urandom_range(0, 39) == 0);
            s.rdy = ($urandom_range(0, 9) < 7);
            s.lka = pick_addr();
            off   = $urandom_range(0, (mq.size() < SQ_DEPTH) ? mq.size() : SQ_DEPTH - 1);
            s.lkp = (head_seq + off) % SQ_DEPTH;
            step(s);
        end

        drive_idle();
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
